// File: rtl/acc_writeback_ctrl_pkg.sv
// Shared types and defaults for the accumulator writeback controller.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DATA_W        = 16;
  localparam int DEF_BEATS_PER_OUT = 25;
  localparam int DEF_NUM_OUT       = 576;
  localparam int DEF_ADDR_W        = 10;

  // Counter width for a given modulus; a modulus of 1 still needs one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/acc_writeback_ctrl_mod_counter.sv
// Modulus counter: counts 0..MODULUS-1 on inc, wraps, with sync clear and
// a terminal-count flag that is high while the count sits at MODULUS-1.
module mod_counter
  import acc_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int WIDTH   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MODULUS - 1));

  // Count register: clear has priority over increment, wrap at terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/acc_writeback_ctrl.sv
// Sequencer and writeback stage behind the convolution accumulator: frames
// input beats into windows, captures each window sum one cycle after its
// last beat, applies optional ReLU and writes it to the output buffer.
module acc_writeback_ctrl
  import acc_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BEATS_PER_OUT = DEF_BEATS_PER_OUT,
  parameter int NUM_OUT       = DEF_NUM_OUT,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter bit RELU_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] acc_sum,
  output logic              acc_enable,
  output logic              acc_clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int BEAT_W = cnt_width(BEATS_PER_OUT);

  state_t              state;
  state_t              state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                beat_tc;
  logic [ADDR_W-1:0]   out_cnt;
  logic                out_tc;
  logic                pend;
  logic                start_accept;
  logic                beat_inc;
  logic                last_window;

  // Negative sums clamp to zero when ReLU is enabled; no saturation otherwise.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return (RELU_EN && x[DATA_W-1]) ? '0 : x;
  endfunction

  assign start_accept = (state == IDLE) && start;
  assign beat_inc     = (state == RUN) && in_valid;

  // While a capture is pending, out_cnt still names the previous window, so
  // the window currently receiving beats is out_cnt+1.
  assign last_window  = pend ? (out_cnt == ADDR_W'(NUM_OUT - 2)) : out_tc;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  mod_counter #(
    .MODULUS (BEATS_PER_OUT),
    .WIDTH   (BEAT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_accept),
    .inc   (beat_inc),
    .count (beat_cnt),
    .tc    (beat_tc)
  );

  mod_counter #(
    .MODULUS (NUM_OUT),
    .WIDTH   (ADDR_W)
  ) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_accept),
    .inc   (pend),
    .count (out_cnt),
    .tc    (out_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and accumulator control.
  always_comb begin
    state_next = state;
    acc_enable = 1'b0;
    acc_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        acc_enable = in_valid;
        acc_clear  = in_valid && (beat_cnt == '0);
        if (in_valid && beat_tc && last_window) state_next = DRAIN;
      end
      DRAIN: begin
        if (pend) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending flag: the accumulator shows the finished sum the cycle after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= beat_inc && beat_tc;
    end
  end

  // Writeback registers: capture the window sum while pend is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pend;
      if (pend) begin
        wr_addr <= out_cnt;
        wr_data <= relu(acc_sum);
      end
    end
  end

endmodule

// File: tb/tb_acc_writeback_ctrl.sv
// Directed bench for acc_writeback_ctrl: a ReLU instance and a pass-through
// instance share stimulus with BEATS_PER_OUT=3, NUM_OUT=4; a third instance
// uses BEATS_PER_OUT=1. A small accumulator model feeds acc_sum.
module tb_acc_writeback_ctrl;

  typedef struct {
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] prod;
    logic        exp_en;
    logic        exp_clr;
    logic        exp_wr;
    logic [9:0]  exp_addr;
    logic [15:0] exp_data;
    logic [15:0] exp_data_nr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] prod = '0;
  logic [15:0] acc_sum;
  logic        acc_enable, acc_clear, wr_en, busy, done;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  logic        en_nr, clr_nr, wr_en_nr, busy_nr, done_nr;
  logic [9:0]  addr_nr;
  logic [15:0] data_nr;

  logic        rst_b1 = 1'b1;
  logic        start_b1 = 1'b0;
  logic        in_valid_b1 = 1'b0;
  logic [15:0] prod_b1 = '0;
  logic [15:0] acc_sum_b1;
  logic        en_b1, clr_b1, wr_en_b1, busy_b1, done_b1;
  logic [9:0]  addr_b1;
  logic [15:0] data_b1;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  acc_writeback_ctrl #(.DATA_W(16), .BEATS_PER_OUT(3), .NUM_OUT(4), .ADDR_W(10), .RELU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .acc_sum(acc_sum),
    .acc_enable(acc_enable), .acc_clear(acc_clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done));

  acc_writeback_ctrl #(.DATA_W(16), .BEATS_PER_OUT(3), .NUM_OUT(4), .ADDR_W(10), .RELU_EN(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .acc_sum(acc_sum),
    .acc_enable(en_nr), .acc_clear(clr_nr), .wr_en(wr_en_nr), .wr_addr(addr_nr),
    .wr_data(data_nr), .busy(busy_nr), .done(done_nr));

  acc_writeback_ctrl #(.DATA_W(16), .BEATS_PER_OUT(1), .NUM_OUT(4), .ADDR_W(10), .RELU_EN(1'b1)) dut_b1 (
    .clk(clk), .rst(rst_b1), .start(start_b1), .in_valid(in_valid_b1), .acc_sum(acc_sum_b1),
    .acc_enable(en_b1), .acc_clear(clr_b1), .wr_en(wr_en_b1), .wr_addr(addr_b1),
    .wr_data(data_b1), .busy(busy_b1), .done(done_b1));

  // Accumulator model for the shared instances: clear restarts from the current product.
  always_ff @(posedge clk) begin
    if (rst) acc_sum <= '0;
    else if (acc_enable) acc_sum <= (acc_clear ? 16'h0000 : acc_sum) + prod;
  end

  // Accumulator model for the single-beat-window instance.
  always_ff @(posedge clk) begin
    if (rst_b1) acc_sum_b1 <= '0;
    else if (en_b1) acc_sum_b1 <= (clr_b1 ? 16'h0000 : acc_sum_b1) + prod_b1;
  end

  function automatic vec_t mk(input logic r, s, iv, input logic [15:0] p,
                              input logic en, clr, wr, input logic [9:0] addr,
                              input logic [15:0] data, data_nr_e, input logic bsy, dn);
    vec_t v;
    v.rst = r; v.start = s; v.in_valid = iv; v.prod = p;
    v.exp_en = en; v.exp_clr = clr; v.exp_wr = wr; v.exp_addr = addr;
    v.exp_data = data; v.exp_data_nr = data_nr_e; v.exp_busy = bsy; v.exp_done = dn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one table row, compare at the falling edge, advance past the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    rst = v.rst; start = v.start; in_valid = v.in_valid; prod = v.prod;
    @(negedge clk);
    checkOutput($sformatf("row%0d acc_enable", idx), acc_enable, v.exp_en);
    checkOutput($sformatf("row%0d acc_clear", idx), acc_clear, v.exp_clr);
    checkOutput($sformatf("row%0d wr_en", idx), wr_en, v.exp_wr);
    checkOutput($sformatf("row%0d wr_addr", idx), wr_addr, v.exp_addr);
    checkOutput($sformatf("row%0d wr_data", idx), wr_data, v.exp_data);
    checkOutput($sformatf("row%0d busy", idx), busy, v.exp_busy);
    checkOutput($sformatf("row%0d done", idx), done, v.exp_done);
    checkOutput($sformatf("row%0d nr wr_data", idx), data_nr, v.exp_data_nr);
    checkOutput($sformatf("row%0d nr wr_en", idx), wr_en_nr, v.exp_wr);
    checkOutput($sformatf("row%0d nr wr_addr", idx), addr_nr, v.exp_addr);
    checkOutput($sformatf("row%0d nr busy", idx), busy_nr, v.exp_busy);
    checkOutput($sformatf("row%0d nr done", idx), done_nr, v.exp_done);
    checkOutput($sformatf("row%0d nr acc_enable", idx), en_nr, v.exp_en);
    checkOutput($sformatf("row%0d nr acc_clear", idx), clr_nr, v.exp_clr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full frame with continuous beats of 10; start pulses in RUN and DONE, in_valid in IDLE.
    tbl.push_back(mk(0,1,0,16'd0,  0,0,0, 10'd0,16'd0,16'd0,   0,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,1,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,1,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,1, 10'd0,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,1,1,16'd10, 1,0,0, 10'd0,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,1,0, 10'd0,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,1, 10'd1,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,0, 10'd1,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,1,0, 10'd1,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,1, 10'd2,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 1,0,0, 10'd2,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd10, 0,0,0, 10'd2,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,1,0,16'd0,  0,0,1, 10'd3,16'd30,16'd30, 1,1));
    tbl.push_back(mk(0,0,1,16'd10, 0,0,0, 10'd3,16'd30,16'd30, 0,0));
    tbl.push_back(mk(0,0,0,16'd0,  0,0,0, 10'd3,16'd30,16'd30, 0,0));
    // Gapped beats summing to -5, then a 0x7FFF window.
    tbl.push_back(mk(0,1,0,16'd0,     0,0,0, 10'd3,16'd30,16'd30, 0,0));
    tbl.push_back(mk(0,0,1,16'd7,     1,1,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'd8,     1,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,1,16'hFFEC,  1,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd3,16'd30,16'd30, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,1, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,1,16'h7000,  1,1,0, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,1,16'h0F00,  1,0,0, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,1,16'h00FF,  1,0,0, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,0, 10'd0,16'd0,16'hFFFB, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,     0,0,1, 10'd1,16'h7FFF,16'h7FFF, 1,0));
    // Reset during the pending cycle, then a fresh frame writes from address 0.
    tbl.push_back(mk(0,0,1,16'd1,  1,1,0, 10'd1,16'h7FFF,16'h7FFF, 1,0));
    tbl.push_back(mk(0,0,1,16'd1,  1,0,0, 10'd1,16'h7FFF,16'h7FFF, 1,0));
    tbl.push_back(mk(0,0,1,16'd1,  1,0,0, 10'd1,16'h7FFF,16'h7FFF, 1,0));
    tbl.push_back(mk(1,0,0,16'd0,  0,0,0, 10'd1,16'h7FFF,16'h7FFF, 1,0));
    tbl.push_back(mk(0,0,0,16'd0,  0,0,0, 10'd0,16'd0,16'd0,   0,0));
    tbl.push_back(mk(0,1,0,16'd0,  0,0,0, 10'd0,16'd0,16'd0,   0,0));
    tbl.push_back(mk(0,0,1,16'd2,  1,1,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd2,  1,0,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,1,16'd2,  1,0,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,0,16'd0,  0,0,0, 10'd0,16'd0,16'd0,   1,0));
    tbl.push_back(mk(0,0,0,16'd0,  0,0,1, 10'd0,16'd6,16'd6,   1,0));
    tbl.push_back(mk(1,0,0,16'd0,  0,0,0, 10'd0,16'd6,16'd6,   1,0));
    tbl.push_back(mk(0,0,0,16'd0,  0,0,0, 10'd0,16'd0,16'd0,   0,0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_b1 = 1'b0;
    @(negedge clk);
    checkOutput("reset wr_en", wr_en, 1'b0);
    checkOutput("reset wr_addr", wr_addr, 10'd0);
    checkOutput("reset wr_data", wr_data, 16'd0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset acc_enable", acc_enable, 1'b0);
    checkOutput("reset b1 busy", busy_b1, 1'b0);
    checkOutput("reset b1 wr_en", wr_en_b1, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);

    // Single-beat windows: writes on four consecutive cycles, done with the last.
    for (int c = 0; c < 12; c++) begin
      start_b1    = (c == 0);
      in_valid_b1 = (c >= 1 && c <= 4);
      prod_b1     = 16'(c);
      @(negedge clk);
      checkOutput($sformatf("b1 c%0d wr_en", c), wr_en_b1, (c >= 3 && c <= 6));
      checkOutput($sformatf("b1 c%0d done", c), done_b1, (c == 6));
      checkOutput($sformatf("b1 c%0d busy", c), busy_b1, (c >= 1 && c <= 6));
      if (c >= 3 && c <= 6) begin
        checkOutput($sformatf("b1 c%0d wr_addr", c), addr_b1, 32'(c - 3));
        checkOutput($sformatf("b1 c%0d wr_data", c), data_b1, 32'(c - 2));
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_writeback_ctrl.md
Name: acc_writeback_ctrl

Overview:
- Sequencer and writeback stage directly downstream of the 4-input convolution accumulator.
- Drives the accumulator's enable/clear so each output window spans exactly BEATS_PER_OUT input beats, counted from upstream valid beats.
- Captures each finished window sum, applies optional ReLU, and writes it to the output feature-map buffer at an auto-incrementing address.
- Signals frame completion to the top-level controller.

Parameters:
- DATA_W, 16, accumulator sum / write data width (two's complement)
- BEATS_PER_OUT, 25, input beats per output pixel (5x5 kernel over 4 lanes); must be ≥1
- NUM_OUT, 576, outputs per frame (24x24 map); must be ≥1
- ADDR_W, 10, output buffer address width; 2**ADDR_W ≥ NUM_OUT
- RELU_EN, 1, 1 = clamp negative sums to 0; 0 = pass through

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin a frame (honoured only in IDLE)
- in_valid  in  1  upstream presents one valid beat of 4 products to the accumulator this cycle
- acc_sum  in  DATA_W  accumulator's registered sum
- acc_enable  out  1  accumulator enable (combinational)
- acc_clear  out  1  accumulator clear/restart (combinational)
- wr_en  out  1  output buffer write strobe (registered)
- wr_addr  out  ADDR_W  output buffer address (registered)
- wr_data  out  DATA_W  output buffer data (registered)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse: last write issued

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; beat_cnt, out_cnt and pend clear to 0.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - rst overrides start and in_valid in the same cycle.
  - Reset mid-frame aborts it: no further wr_en; any pending write is dropped.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN, out_cnt=0, beat_cnt=0. in_valid is ignored.
- RUN:
  - acc_enable = in_valid.
  - acc_clear = in_valid && beat_cnt==0, so the first beat of a window overwrites the stale sum.
  - Each valid beat increments beat_cnt; at BEATS_PER_OUT-1 it wraps to 0 and sets pend for the next cycle.
  - Cycles without in_valid hold all counters; acc_enable=0.
  - On the last beat of output NUM_OUT-1 → DRAIN.
- Writeback pipeline:
  - In the cycle with pend=1, acc_sum holds the completed window sum.
  - At that edge: wr_data ← f(acc_sum), wr_addr ← out_cnt, wr_en ← 1; out_cnt increments.
  - wr_en is therefore high exactly 2 cycles after the cycle presenting the window's last beat, for one cycle.
  - Back-to-back windows are legal. The new window's clear beat may coincide with pend, and the capture samples the pre-update sum.
  - BEATS_PER_OUT=1 with continuous in_valid yields wr_en every cycle.
- f(x): if RELU_EN and x[DATA_W-1]==1 → 0, else x. No saturation; accumulator overflow wraps modulo 2**DATA_W.
- DRAIN: acc_enable=0; waits for the final pend capture, then → DONE.
- DONE: done=1 for one cycle, the same cycle as the final wr_en; → IDLE.
- busy = (state != IDLE). start while busy is ignored.
- wr_addr keeps its last value between writes.

Decomposition:
- Shared package acc_pkg:
  - State enum type (IDLE/RUN/DRAIN/DONE).
  - Default constants DATA_W=16, BEATS_PER_OUT=25, NUM_OUT=576, ADDR_W=10.
- One natural sub-module: mod_counter.
  - Parameterised modulus counter with inc, sync clear, terminal-count flag.
  - Instantiated twice: beat counter and output counter.

Test Plan (BEATS_PER_OUT=3, NUM_OUT=4, RELU_EN=1 unless stated):
1. Reset, then start, then continuous in_valid; acc model sums 10 per beat → wr_en at addr 0,1,2,3 with data 30 each; first wr_en 2 cycles after the 3rd beat; done coincides with addr-3 write; busy then falls.
2. in_valid gaps (pattern 1,0,0,1,0,1) → acc_clear only on the first beat; single write after the 3rd valid beat; no acc_enable in gap cycles.
3. Window sum -5 (0xFFFB) → wr_data=0. With RELU_EN=0 → wr_data=0xFFFB. Sum 0x7FFF → 0x7FFF.
4. start pulsed during RUN and in DONE → ignored, out_cnt unchanged, exactly 4 writes. in_valid in IDLE → acc_enable stays 0.
5. rst asserted in the cycle pend=1 → no wr_en follows, all outputs 0 next cycle. A new start then writes from addr 0.
6. BEATS_PER_OUT=1, NUM_OUT=4, continuous in_valid with sums 1,2,3,4 → wr_en 4 consecutive cycles, data 1,2,3,4 at addr 0..3; done on the 4th.
